// File: rtl/apb_m_arbiter.sv
// apb_m_arbiter: two-requester APB master with round-robin arbitration.
// Each granted transfer runs IDLE -> SETUP -> ACCESS and inserts wait states
// while pready is low. Completion is a one-cycle reqN_done pulse, with
// rsp_rdata and rsp_err valid in that same cycle.
// Optional build macro APB_TIMEOUT_EN: abandon an ACCESS phase after
// TIMEOUT_CYCLES cycles and report rsp_err = 1. Without the macro, ACCESS
// waits indefinitely and rsp_err is always 0.
module apb_m_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_done,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_last_grant;   // also identifies the requester being served
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_done0;
  logic                  r_done1;

  logic                  w_grant;
  logic                  w_grant_id;
  logic                  w_complete;
  logic                  w_timeout;
  logic                  w_to_hit;
  logic                  w_psel;
  logic                  w_penable;
  logic                  w_bad;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_to_cnt;

  assign w_to_hit = (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count wait-state ACCESS cycles; clear whenever the ACCESS phase ends.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_ACCESS && w_state_next == ST_ACCESS) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  // No timeout in this build: the comparison is constant false.
  assign w_to_hit = (TIMEOUT_CYCLES < 0);
`endif

  // State register with asynchronous reset back to IDLE.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode, arbitration and APB strobes.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_id   = r_last_grant;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    w_psel       = 1'b0;
    w_penable    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A requester still sees its done pulse this cycle and has not yet
        // dropped valid, so no grant is made while any done is high.
        if ((req0_valid || req1_valid) && !(r_done0 || r_done1)) begin
          w_grant = 1'b1;
          if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
          end else begin
            w_grant_id = req1_valid;
          end
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_psel       = 1'b1;
        w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_psel    = 1'b1;
        w_penable = 1'b1;
        if (pready) begin
          w_complete   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_to_hit) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Transfer latch at grant, response capture and done pulse at completion.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_last_grant <= 1'b1;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      if (w_grant) begin
        r_last_grant <= w_grant_id;
        r_pwrite     <= w_grant_id ? req1_write : req0_write;
        r_paddr      <= w_grant_id ? req1_addr  : req0_addr;
        r_pwdata     <= w_grant_id ? req1_wdata : req0_wdata;
      end
      if (w_complete || w_timeout) begin
        r_done0 <= ~r_last_grant;
        r_done1 <= r_last_grant;
        r_err   <= w_timeout;
        if (w_complete && !r_pwrite) begin
          r_rdata <= prdata;
        end
      end
    end
  end

  // The unused state code forces every output low until it returns to IDLE.
  assign w_bad     = (r_state == ST_BAD);
  assign psel      = w_psel;
  assign penable   = w_penable;
  assign pwrite    = r_pwrite & ~w_bad;
  assign paddr     = w_bad ? '0 : r_paddr;
  assign pwdata    = w_bad ? '0 : r_pwdata;
  assign rsp_rdata = w_bad ? '0 : r_rdata;
  assign rsp_err   = r_err & ~w_bad;
  assign req0_done = r_done0 & ~w_bad;
  assign req1_done = r_done1 & ~w_bad;

endmodule

// File: tb/tb_apb_m_arbiter.sv
// Bench for apb_m_arbiter: requester models feed per-requester scoreboards,
// an APB slave model inserts wait states, and every SETUP / done is checked
// against the expected grant order and transfer contents.
module tb_apb_m_arbiter;

`ifdef APB_TIMEOUT_EN
  localparam int TO_P     = 4;
  localparam int TO_MODEL = 4;
`else
  localparam int TO_P     = 16;
  localparam int TO_MODEL = 1000000;
`endif

  typedef struct {
    bit          id;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;   // slave response, and expected rsp_rdata for reads
    int          waits;
  } xfer_t;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic        req0_done, req1_done, rsp_err, psel, penable, pwrite;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;

  apb_m_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO_P)) dut (
    .pclk(pclk), .presetn(presetn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  xfer_t       pend0[$], pend1[$], ex0[$], ex1[$];
  bit          order_q[$];
  xfer_t       cur;
  bit          cur_id = 1'b0;
  bit          active = 1'b0;
  int          checks = 0, errors = 0;
  int          cyc = 0, setup_cyc = 0, last_setup = -1000, acc_cnt = 0;
  logic [31:0] rdata_model = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit busy();
    return (pend0.size() != 0) || (pend1.size() != 0) || (ex0.size() != 0) ||
           (ex1.size() != 0) || (order_q.size() != 0) || active;
  endfunction

  // Requesters, APB slave and checker, all evaluated on the falling edge.
  always @(negedge pclk) begin
    xfer_t t;
    bit    exp_err;
    cyc++;
    if (!presetn) begin
      pready     = 1'b0;
      acc_cnt    = 0;
      active     = 1'b0;
      last_setup = -1000;
    end else begin
      if (req0_done || req1_done) begin
        chk("done_onehot", 64'(req0_done & req1_done), 64'd0);
        if (!active) begin
          errors++;
          $display("FAIL unexpected_done: got done0=%0b done1=%0b, expected none", req0_done, req1_done);
        end else begin
          exp_err = (cur.waits >= TO_MODEL);
          chk("done_id", 64'(req1_done), 64'(cur_id));
          chk("latency", 64'(cyc - setup_cyc), 64'(2 + (exp_err ? TO_MODEL - 1 : cur.waits)));
          chk("rsp_err", 64'(rsp_err), 64'(exp_err));
          if (!cur.wr && !exp_err) rdata_model = cur.rdata;
          chk("rsp_rdata", 64'(rsp_rdata), 64'(rdata_model));
          $display("xfer id=%0d %s addr=0x%0h waits=%0d rdata=0x%0h err=%0b",
                   cur_id, cur.wr ? "WR" : "RD", cur.addr, cur.waits, rsp_rdata, rsp_err);
          active = 1'b0;
        end
        if (req1_done) begin
          if (ex1.size() != 0) void'(ex1.pop_front());
          req1_valid = 1'b0;
        end
        if (req0_done) begin
          if (ex0.size() != 0) void'(ex0.pop_front());
          req0_valid = 1'b0;
        end
      end

      if (psel && !penable) begin
        if (active || order_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_setup: got psel=1 active=%0b, expected no grant", active);
        end else begin
          cur_id = order_q.pop_front();
          if ((cur_id ? ex1.size() : ex0.size()) == 0) begin
            errors++;
            $display("FAIL grant_empty: got grant to %0d, expected a pending request", cur_id);
          end else begin
            cur = cur_id ? ex1[0] : ex0[0];
            chk("setup_paddr", 64'(paddr), 64'(cur.addr));
            chk("setup_pwrite", 64'(pwrite), 64'(cur.wr));
            if (cur.wr) chk("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
            chk("setup_spacing", 64'((cyc - last_setup) >= 4), 64'd1);
            active     = 1'b1;
            setup_cyc  = cyc;
            last_setup = cyc;
          end
        end
      end

      if (psel && penable) begin
        if (!active) begin
          errors++;
          $display("FAIL stray_access: got penable=1, expected idle bus");
        end else begin
          chk("access_paddr", 64'(paddr), 64'(cur.addr));
          chk("access_pwrite", 64'(pwrite), 64'(cur.wr));
        end
        pready  = (acc_cnt >= cur.waits);
        prdata  = pready ? cur.rdata : ~cur.rdata;
        acc_cnt = acc_cnt + 1;
      end else begin
        pready  = 1'b0;
        acc_cnt = 0;
      end

      if (!req0_valid && pend0.size() != 0) begin
        t = pend0.pop_front();
        req0_valid = 1'b1; req0_write = t.wr; req0_addr = t.addr; req0_wdata = t.wdata;
        ex0.push_back(t);
      end
      if (!req1_valid && pend1.size() != 0) begin
        t = pend1.pop_front();
        req1_valid = 1'b1; req1_write = t.wr; req1_addr = t.addr; req1_wdata = t.wdata;
        ex1.push_back(t);
      end
    end
  end

  task automatic push(input xfer_t t);
    if (t.id) pend1.push_back(t);
    else      pend0.push_back(t);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 600 && busy(); i++) @(posedge pclk);
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s_timeout: got outstanding work after 600 cycles, expected idle", name);
    end
    @(posedge pclk); #1;
  endtask

  xfer_t tbl[6];

  initial begin
    tbl[0] = '{id: 1'b0, wr: 1'b1, addr: 32'h10, wdata: 32'hA5A5_0001, rdata: 32'h0,         waits: 0};
    tbl[1] = '{id: 1'b1, wr: 1'b0, addr: 32'h20, wdata: 32'h0,         rdata: 32'hDEAD_BEEF, waits: 2};
    tbl[2] = '{id: 1'b0, wr: 1'b1, addr: 32'h44, wdata: 32'h1234_5678, rdata: 32'h0,         waits: 1};
    tbl[3] = '{id: 1'b0, wr: 1'b0, addr: 32'h48, wdata: 32'h0,         rdata: 32'h0BAD_F00D, waits: 0};
    tbl[4] = '{id: 1'b1, wr: 1'b1, addr: 32'h4C, wdata: 32'hFFFF_0000, rdata: 32'h0,         waits: 3};
    tbl[5] = '{id: 1'b1, wr: 1'b0, addr: 32'h50, wdata: 32'h0,         rdata: 32'h0000_0001, waits: 5};

    // Reset state.
    #1;
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_done0", 64'(req0_done), 64'd0);
    chk("rst_done1", 64'(req1_done), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);

    // Both requesters valid out of reset, two transfers each: 0,1,0,1.
    push('{id: 1'b0, wr: 1'b1, addr: 32'h100, wdata: 32'h0000_1000, rdata: 32'h0,         waits: 0});
    push('{id: 1'b0, wr: 1'b0, addr: 32'h104, wdata: 32'h0,         rdata: 32'h1111_2222, waits: 1});
    push('{id: 1'b1, wr: 1'b0, addr: 32'h200, wdata: 32'h0,         rdata: 32'h3333_4444, waits: 0});
    push('{id: 1'b1, wr: 1'b1, addr: 32'h204, wdata: 32'h0000_2004, rdata: 32'h0,         waits: 2});
    order_q.push_back(1'b0); order_q.push_back(1'b1);
    order_q.push_back(1'b0); order_q.push_back(1'b1);
    @(negedge pclk); #2 presetn = 1'b1;
    wait_idle("simultaneous");

    // Single-requester vectors.
    for (int i = 0; i < 6; i++) begin
      push(tbl[i]);
      order_q.push_back(tbl[i].id);
      wait_idle("vector");
    end

    // Fairness: req0 twice alone, then both together -> req1 first.
    push('{id: 1'b0, wr: 1'b1, addr: 32'h300, wdata: 32'h0000_0300, rdata: 32'h0, waits: 0});
    push('{id: 1'b0, wr: 1'b1, addr: 32'h304, wdata: 32'h0000_0304, rdata: 32'h0, waits: 0});
    order_q.push_back(1'b0); order_q.push_back(1'b0);
    wait_idle("fair_pre");
    push('{id: 1'b0, wr: 1'b0, addr: 32'h308, wdata: 32'h0, rdata: 32'h5555_0308, waits: 0});
    push('{id: 1'b1, wr: 1'b0, addr: 32'h30C, wdata: 32'h0, rdata: 32'h6666_030C, waits: 1});
    order_q.push_back(1'b1); order_q.push_back(1'b0);
    wait_idle("fairness");

`ifdef APB_TIMEOUT_EN
    // Timeout abort, then pready rising on the last allowed ACCESS cycle.
    push('{id: 1'b0, wr: 1'b0, addr: 32'h400, wdata: 32'h0, rdata: 32'h7777_0400, waits: 50});
    order_q.push_back(1'b0);
    wait_idle("timeout_abort");
    push('{id: 1'b1, wr: 1'b0, addr: 32'h404, wdata: 32'h0, rdata: 32'h8888_0404, waits: 3});
    order_q.push_back(1'b1);
    wait_idle("timeout_edge");
`endif

    // Reset during a stalled ACCESS of requester 0.
    push('{id: 1'b0, wr: 1'b0, addr: 32'h500, wdata: 32'h0, rdata: 32'h9999_0500, waits: 200});
    order_q.push_back(1'b0);
    begin
      int n = 0;
      while (!(psel && penable) && n < 50) begin
        @(negedge pclk);
        n++;
      end
      chk("reset_reach_access", 64'(psel && penable), 64'd1);
    end
    repeat (2) @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    chk("async_psel", 64'(psel), 64'd0);
    chk("async_penable", 64'(penable), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    pend0.delete(); pend1.delete(); ex0.delete(); ex1.delete(); order_q.delete();
    rdata_model = '0;
    repeat (3) begin
      @(negedge pclk); #1;
      chk("reset_no_done", 64'({req0_done, req1_done}), 64'd0);
    end
    push('{id: 1'b0, wr: 1'b1, addr: 32'h600, wdata: 32'h0000_0600, rdata: 32'h0, waits: 0});
    push('{id: 1'b1, wr: 1'b1, addr: 32'h604, wdata: 32'h0000_0604, rdata: 32'h0, waits: 0});
    order_q.push_back(1'b0); order_q.push_back(1'b1);
    @(negedge pclk); #2 presetn = 1'b1;
    wait_idle("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_m_arbiter.md
Name: apb_m_arbiter

Overview:
- Two-requester APB master controller that drives the APB slave interface (psel/penable/pwrite/paddr/pwdata) and collects prdata/pready.
- Arbitrates requests round-robin and sequences each transfer through the IDLE -> SETUP -> ACCESS protocol, inserting wait states while pready is low.
- Returns read data and a one-cycle completion pulse to the granted requester.
- Sits between internal bus masters and the APB peripheral slaves.

Parameters:
- ADDR_WIDTH, 32, width of paddr and requester addresses.
- DATA_WIDTH, 32, width of pwdata, prdata and requester data.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; used only with the optional feature; must be >= 2.

Ports:
- pclk  input  1  APB clock; all logic on rising edge.
- presetn  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 transfer request; held until req0_done.
- req0_write  input  1  requester 0 direction, 1 = write.
- req0_addr  input  ADDR_WIDTH  requester 0 address.
- req0_wdata  input  DATA_WIDTH  requester 0 write data.
- req0_done  output  1  one-cycle completion pulse to requester 0.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_done  same as requester 0, for requester 1.
- rsp_rdata  output  DATA_WIDTH  read data of the last completed read; valid in the cycle of reqN_done.
- rsp_err  output  1  error flag; valid in the cycle of reqN_done.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_WIDTH  APB address.
- pwdata  output  DATA_WIDTH  APB write data.
- prdata  input  DATA_WIDTH  APB read data.
- pready  input  1  APB slave ready.

Behaviour:
- Reset (presetn low, asynchronous): every output is 0, state = IDLE, last_grant = 1 (so requester 0 wins the first tie), timeout counter = 0.
- State register: 2 bits. IDLE = 00, SETUP = 01, ACCESS = 10. Code 11 goes to IDLE and drives all outputs 0.
- IDLE:
  - psel = penable = 0.
  - If any reqN_valid is high and no reqN_done is asserted this cycle: grant one requester, latch its addr/wdata/write into paddr/pwdata/pwrite, go to SETUP.
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1. Both valid -> grant the one != last_grant.
  - last_grant updates on grant.
- SETUP (exactly one cycle): psel = 1, penable = 0, then go to ACCESS.
- ACCESS: psel = 1, penable = 1.
  - pready = 0: stay in ACCESS (wait state); paddr/pwdata/pwrite held stable.
  - pready = 1: go to IDLE. At the same edge, rsp_rdata <= prdata for reads (unchanged for writes), rsp_err <= 0, and the granted reqN_done <= 1 for exactly one cycle.
- Latency: with no wait states, grant edge to done-high is 3 cycles. Each pready-low cycle in ACCESS adds 1 cycle.
- Back-to-back transfers:
  - While done is high, the requester has not yet dropped valid, so IDLE ignores requests in that cycle.
  - Minimum spacing from one SETUP to the next SETUP is 4 cycles.
- Requester contract: valid/addr/wdata/write must be stable from assertion until done. Dropping valid before done does not abort a transfer already granted.
- paddr/pwdata/pwrite retain their last values in IDLE. They are 0 only after reset.
- Reset mid-transfer: psel/penable drop immediately (asynchronous), no done pulse, the transfer is lost, and last_grant returns to 1.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter increments on each ACCESS cycle with pready = 0 and clears on leaving ACCESS.
  - When the count reaches TIMEOUT_CYCLES - 1 with pready still low, the transfer is abandoned: go to IDLE, pulse the granted reqN_done, set rsp_err = 1, leave rsp_rdata unchanged.
  - If pready = 1 on that same cycle, normal completion wins and rsp_err = 0.
- Undefined: no counter; ACCESS waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Write, no wait: req0 write, addr 0x10, wdata 0xA5A5_0001, pready held 1 -> SETUP cycle 1 (psel=1, penable=0), ACCESS cycle 2 (penable=1), req0_done=1 in cycle 3, rsp_err=0.
- Read with 2 wait states: req1 read, addr 0x20, pready low for 2 ACCESS cycles, prdata=0xDEAD_BEEF -> ACCESS lasts 3 cycles, req1_done with rsp_rdata=0xDEAD_BEEF, total 5 cycles.
- Simultaneous requests out of reset: both valid, both held for 4 transfers -> grant order 0,1,0,1; each done pulses once per transfer; no overlap of psel across grants.
- Fairness: req0 only for 2 transfers, then both valid -> req1 is granted next.
- Reset during ACCESS with pready=0: presetn low -> psel=penable=0 in the same cycle, no done; after release with both valid, req0 is granted first.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready held 0 -> done after 4 ACCESS cycles with rsp_err=1. Rerun with pready rising in the 4th ACCESS cycle -> rsp_err=0 and rdata captured.
